// File: rtl/pc_unit_if.sv
// pc_unit_if -- bundle of the fetch-control signals of pc_unit.
//
// Parameter ADDR_W : address width (must match the pc_unit instance).
// slave modport (pc_unit side):
//   inputs  : stall, br_flag, br_target, flush, flush_pc, halt
//   outputs : pc, ce, pend, misalign
// master modport (pipeline / control side): same signals, opposite directions.
interface pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              br_flag;
    logic [ADDR_W-1:0] br_target;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pend;
    logic              misalign;

    modport master (
        output stall, br_flag, br_target, flush, flush_pc, halt,
        input  pc, ce, pend, misalign
    );

    modport slave (
        input  stall, br_flag, br_target, flush, flush_pc, halt,
        output pc, ce, pend, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- program counter / fetch-enable generator.
//
// Parameters:
//   ADDR_W   : pc and target width (>= 8)
//   RESET_PC : first fetch address after reset
//   STEP     : sequential increment in bytes
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : pc_unit_if.slave -- stall/br_flag/br_target/flush/flush_pc/halt in,
//          pc/ce/pend/misalign out (all outputs registered)
// Optional feature macro: PC_ALIGN_CHECK_EN
//   When defined, every loaded redirect target has bits [1:0] cleared and a
//   non-zero [1:0] raises misalign for one cycle. When undefined, targets are
//   loaded as-is and misalign is tied low.
//
// Behaviour notes:
//   - OFF -> RUN on the first edge after reset release with pc unchanged, so
//     the first ce=1 cycle fetches RESET_PC.
//   - The edge that enters HALT holds pc, so the address presented on that
//     cycle is fetched again after resume. The resume edge also holds pc.
//   - stall holds the ce-state as well, so neither halting nor resuming
//     happens on a stalled edge.
//   - A branch that cannot be taken (stall, halt entry, or HALT) is parked in
//     the pending register; a newer one overwrites it.
module pc_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 STEP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    typedef enum logic [1:0] {OFF, RUN, HALT} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              ce_reg, ce_next;
    logic              pend_reg, pend_next;
    logic [ADDR_W-1:0] tgt_reg, tgt_next;
    logic              load;
    logic [ADDR_W-1:0] load_addr;

    function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return {a[ADDR_W-1:2], 2'b00};
`else
        return a;
`endif
    endfunction

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ce_next    = ce_reg;
        pend_next  = pend_reg;
        tgt_next   = tgt_reg;
        load       = 1'b0;
        load_addr  = '0;
        unique case (state_reg)
            OFF: begin
                // Redirect inputs are ignored until the first fetch cycle.
                state_next = RUN;
                ce_next    = 1'b1;
            end
            RUN: begin
                if (bus.flush) begin
                    load      = 1'b1;
                    load_addr = bus.flush_pc;
                    pend_next = 1'b0;
                end else if (bus.stall || bus.halt) begin
                    if (bus.br_flag) begin
                        tgt_next  = bus.br_target;
                        pend_next = 1'b1;
                    end
                    if (!bus.stall) begin
                        state_next = HALT;
                        ce_next    = 1'b0;
                    end
                end else if (bus.br_flag) begin
                    load      = 1'b1;
                    load_addr = bus.br_target;
                    pend_next = 1'b0;
                end else if (pend_reg) begin
                    load      = 1'b1;
                    load_addr = tgt_reg;
                    pend_next = 1'b0;
                end else begin
                    pc_next = pc_reg + ADDR_W'(STEP);
                end
            end
            HALT: begin
                if (bus.flush) begin
                    load      = 1'b1;
                    load_addr = bus.flush_pc;
                    pend_next = 1'b0;
                end else begin
                    if (bus.br_flag) begin
                        tgt_next  = bus.br_target;
                        pend_next = 1'b1;
                    end
                    if (!bus.halt && !bus.stall) begin
                        state_next = RUN;
                        ce_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = OFF;
                ce_next    = 1'b0;
            end
        endcase
        if (load) begin
            pc_next = fix_target(load_addr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= OFF;
            pc_reg    <= RESET_PC;
            ce_reg    <= 1'b0;
            pend_reg  <= 1'b0;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ce_reg    <= ce_next;
            pend_reg  <= pend_next;
            tgt_reg   <= tgt_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= load && (load_addr[1:0] != 2'b00);
        end
    end

    assign bus.misalign = misalign_reg;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc   = pc_reg;
    assign bus.ce   = ce_reg;
    assign bus.pend = pend_reg;
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target width in bits (>= 8).
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset (ADDR_W bits).
REQ-003 Parameter STEP, default 4, sequential increment in bytes.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hold PC and ce-state this cycle.
REQ-007 br_flag  input  1  branch/jump redirect request, one-cycle pulse.
REQ-008 br_target  input  ADDR_W  redirect address, valid with br_flag.
REQ-009 flush  input  1  exception/flush redirect, one-cycle pulse.
REQ-010 flush_pc  input  ADDR_W  handler address, valid with flush.
REQ-011 halt  input  1  level; request fetch stop.
REQ-012 pc  output  ADDR_W  current fetch address, registered.
REQ-013 ce  output  1  fetch enable, registered, 1 = read enable.
REQ-014 pend  output  1  a deferred branch redirect is held.
REQ-015 misalign  output  1  registered misaligned-target flag (PC_ALIGN_CHECK_EN only; tied 0 otherwise).

Function
REQ-016 FSM states OFF, RUN, HALT; ce = 1 only in RUN.
REQ-017 OFF -> RUN on first rising edge with rst deasserted; pc stays RESET_PC on that edge, so first ce=1 cycle fetches RESET_PC.
REQ-018 RUN -> HALT when halt=1 and stall=0; HALT -> RUN when halt=0; pc held in HALT.
REQ-019 RUN update priority per edge: flush > stall > pending/branch > increment.
REQ-020 flush=1 (RUN or HALT): pc <= flush_pc, pending cleared, stall and halt ignored that edge; state unchanged.
REQ-021 stall=1, no flush: pc held; if br_flag=1, br_target captured into pending register and pend <= 1 (newer branch overwrites older).
REQ-022 stall=0, no flush: if br_flag=1, pc <= br_target, pend <= 0; else if pend=1, pc <= pending target, pend <= 0; else pc <= pc + STEP.
REQ-023 Increment wraps modulo 2^ADDR_W (max PC + STEP wraps to low addresses, no flag).
REQ-024 br_flag and flush in OFF state ignored; br_flag in HALT captured into pending as in REQ-021.
REQ-025 Outputs change only on rising clk or reset assertion; no combinational input-to-output path.

Reset
REQ-026 rst=0 asynchronously forces state OFF, pc=RESET_PC, ce=0, pend=0, pending target=0, misalign=0.
REQ-027 Reset mid-operation (any state, any pending) discards all state; recovery per REQ-017.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: any loaded redirect (flush_pc, br_target, pending target) with bits [1:0] != 0 loads with bits [1:0] forced to 0 and sets misalign=1 for one cycle.
REQ-029 Macro PC_ALIGN_CHECK_EN undefined: targets loaded unmodified, misalign tied 0, no check logic present.

Verification
REQ-030 Reset release, no other stimulus, defaults -> ce 0 then 1; pc 0,0,4,8,0xC on consecutive edges.
REQ-031 RUN pc=0x10, br_flag with br_target=0x200 -> next pc=0x200, then 0x204.
REQ-032 pc=0x20, stall 3 cycles, br_flag 0x400 on stall cycle 2 -> pc held 0x20, pend=1; first unstalled edge pc=0x400, pend=0.
REQ-033 Same cycle flush (flush_pc=0x80), br_flag (0x400), stall=1 -> pc=0x80, pend=0.
REQ-034 ADDR_W=8, pc=0xFC -> next pc=0x00; halt=1 -> ce=0, pc held; halt=0 -> ce=1, increment resumes.
REQ-035 PC_ALIGN_CHECK_EN defined, br_target=0x203 -> pc=0x200, misalign pulses 1 cycle; undefined -> pc=0x203, misalign=0.
